mic_capture_ctrl: RTL and testbench
===================================

// Module: mic_capture_ctrl
// PURPOSE
//  Sequencer for the PDM microphone capture path. Drives mic channel select, discards mic
//  wake-up bits, packs 1-bit PDM samples into bytes and writes them into the capture FIFO.
//  Stops after a programmed byte count or on abort, and flags FIFO overflow.
//  Runs entirely in the mic clock domain (mclk, from the frequency divider).
// PARAMETERS
//  SETTLE_CYCLES  1024  mclk cycles of mic_data discarded after each start (mic wake-up)
//  LEN_W          16    width of len and byte_cnt
//  LR_SEL         0     constant value driven on mic_lr_sel (0 = left channel)
// PORTS
//  mclk        in   1      capture clock; all logic on rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      1-cycle request; honoured only in IDLE or DONE
//  abort       in   1      stop request; honoured only in SETTLE or CAPTURE
//  len         in   LEN_W  bytes to capture; latched on accepted start; 0 = continuous
//  mic_data    in   1      PDM bit from microphone
//  mic_lr_sel  out  1      mic L/R select, = LR_SEL at all times incl. reset
//  fifo_full   in   1      capture FIFO full
//  fifo_wr     out  1      1-cycle FIFO write strobe (registered)
//  fifo_din    out  8      packed byte; valid while fifo_wr=1
//  busy        out  1      1 in SETTLE and CAPTURE
//  done        out  1      1 in DONE
//  overflow    out  1      sticky; byte dropped due to fifo_full; cleared on accepted start
//  byte_cnt    out  LEN_W  bytes written to FIFO since last accepted start
// BEHAVIOUR
//  - Reset: state IDLE; fifo_wr, fifo_din, busy, done, overflow, byte_cnt = 0;
//    bit counter and shift register cleared. Reset mid-capture: IDLE at next edge, no fifo_wr.
//  - States: IDLE, SETTLE, CAPTURE, DONE.
//  - IDLE/DONE + start (abort low): -> SETTLE; latch len; clear byte_cnt, overflow,
//    settle counter, bit counter. start in SETTLE/CAPTURE ignored. abort in IDLE/DONE ignored.
//  - start and abort in the same cycle: abort takes priority; in IDLE/DONE nothing happens.
//  - SETTLE: mic_data ignored; after SETTLE_CYCLES cycles in SETTLE -> CAPTURE.
//    SETTLE_CYCLES=0 gives one SETTLE cycle.
//  - CAPTURE: one bit sampled per mclk, MSB first (first bit -> fifo_din[7]); no gaps.
//  - On the edge sampling the 8th bit:
//    - fifo_full=0: register fifo_wr=1, fifo_din=byte, byte_cnt+1.
//      fifo_wr is high for exactly the following cycle; writes occur every 8 cycles.
//    - fifo_full=1: fifo_wr stays 0, byte dropped, overflow<=1, byte_cnt unchanged,
//      capture continues.
//  - Completion: len!=0 and a write makes byte_cnt==len -> DONE on the same edge.
//    That last fifo_wr pulse is high during the first DONE cycle. Dropped bytes never complete.
//  - len=0: continuous capture; byte_cnt wraps modulo 2^LEN_W; exit only via abort or reset.
//  - abort in SETTLE/CAPTURE: -> DONE next edge; partial byte discarded.
//    If abort coincides with an 8th-bit edge, abort wins and no fifo_wr is issued.
//  - byte_cnt and overflow hold their values in DONE until the next accepted start.
// TESTING
//  1. reset 2 cycles mid-CAPTURE -> busy=done=fifo_wr=overflow=0, byte_cnt=0,
//     mic_lr_sel=LR_SEL.
//  2. SETTLE_CYCLES=4, len=2, start; after settle feed bits of 0xA5 then 0x3C
//     -> fifo_wr pulses 8 cycles apart with din 0xA5, 0x3C; done=1, byte_cnt=2, overflow=0.
//  3. len=3, fifo_full=1 on the 1st byte's 8th-bit edge only
//     -> no write, overflow=1; next two bytes written, then byte_cnt=2, still busy.
//  4. abort after 3 bits of the 2nd byte -> DONE next cycle, no extra fifo_wr, byte_cnt=1.
//  5. LEN_W=4, len=0, run 17 bytes -> byte_cnt=1 after wrap, done=0; abort -> done=1.
//  6. start+abort same cycle in IDLE -> stays IDLE.
//     start from DONE with overflow=1 -> overflow=0, byte_cnt=0, busy=1.

Source files
------------

// File: rtl/mic_capture_ctrl_if.sv
// Control, status and capture-FIFO write signals of the PDM mic capture sequencer.
// The sequencer is the FIFO write master; the slave view belongs to the host/FIFO side.
interface mic_capture_ctrl_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] len;
    logic             fifo_full;
    logic             fifo_wr;
    logic [7:0]       fifo_din;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [LEN_W-1:0] byte_cnt;

    modport master (
        input  start, abort, len, fifo_full,
        output fifo_wr, fifo_din, busy, done, overflow, byte_cnt
    );

    modport slave (
        output start, abort, len, fifo_full,
        input  fifo_wr, fifo_din, busy, done, overflow, byte_cnt
    );
endinterface

// File: rtl/mic_capture_ctrl.sv
// PDM mic capture sequencer: discards mic wake-up bits, packs PDM bits MSB first into
// bytes and writes them to the capture FIFO until len bytes are written or abort.
module mic_capture_ctrl #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int LEN_W         = 16,
    parameter bit LR_SEL        = 1'b0
) (
    input  logic               mclk,
    input  logic               reset,
    input  logic               mic_data,
    output logic               mic_lr_sel,
    mic_capture_ctrl_if.master bus
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [SET_W-1:0] settle_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shift;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_inc;
    logic             settle_last;
    logic             byte_edge;
    logic             accept_start;
    logic             write_byte;
    logic             drop_byte;

    assign mic_lr_sel  = LR_SEL;
    assign bus.busy    = (state == SETTLE) || (state == CAPTURE);
    assign bus.done    = (state == DONE);
    assign cnt_inc     = bus.byte_cnt + LEN_W'(1);
    // SETTLE_CYCLES of 0 or 1 both leave SETTLE after its first cycle
    assign settle_last = (SETTLE_CYCLES <= 1) || (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign byte_edge   = (bit_cnt == 3'd7);

    always_ff @(posedge mclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort outranks both start and the 8th-bit write; a dropped byte never completes
    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        write_byte   = 1'b0;
        drop_byte    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start && !bus.abort) begin
                    next_state   = SETTLE;
                    accept_start = 1'b1;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    next_state = DONE;
                end else if (settle_last) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.abort) begin
                    next_state = DONE;
                end else if (byte_edge) begin
                    if (bus.fifo_full) begin
                        drop_byte = 1'b1;
                    end else begin
                        write_byte = 1'b1;
                        if ((len_q != '0) && (cnt_inc == len_q)) begin
                            next_state = DONE;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            settle_cnt   <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            len_q        <= '0;
            bus.fifo_wr  <= 1'b0;
            bus.fifo_din <= '0;
            bus.overflow <= 1'b0;
            bus.byte_cnt <= '0;
        end else begin
            bus.fifo_wr <= write_byte;
            if (accept_start) begin
                len_q        <= bus.len;
                bus.byte_cnt <= '0;
                bus.overflow <= 1'b0;
                settle_cnt   <= '0;
                bit_cnt      <= '0;
            end
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (state == CAPTURE) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {shift[5:0], mic_data};
            end
            if (write_byte) begin
                bus.fifo_din <= {shift, mic_data};
                bus.byte_cnt <= cnt_inc;
            end
            if (drop_byte) begin
                bus.overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Self-checking bench for mic_capture_ctrl: randomized capture runs compared against a
// byte-level reference model (expected bytes, write count, overflow and completion).
module tb_mic_capture_ctrl;
    localparam int SETTLE = 4;
    localparam int LW     = 4;
    localparam int CMOD   = 1 << LW;

    logic mclk = 1'b0;
    logic reset;
    logic mic_data;
    logic mic_lr_sel;

    mic_capture_ctrl_if #(.LEN_W(LW)) bus ();

    mic_capture_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .LEN_W        (LW),
        .LR_SEL       (1'b0)
    ) dut (
        .mclk      (mclk),
        .reset     (reset),
        .mic_data  (mic_data),
        .mic_lr_sel(mic_lr_sel),
        .bus       (bus)
    );

    always #5 mclk = ~mclk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_cnt;
    bit         exp_ovf;
    bit         exp_busy;
    bit         exp_done;
    logic [7:0] fixed_bytes[$];
    bit         full_plan[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at that same point
    task automatic applyStimulus(input bit st, input bit ab, input int ln, input bit d, input bit full);
        bus.start     = st;
        bus.abort     = ab;
        bus.len       = LW'(ln);
        mic_data      = d;
        bus.fifo_full = full;
        @(posedge mclk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input bit exp_wr);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
        checkOutput({tag, ".done"}, 32'(bus.done), 32'(exp_done));
        checkOutput({tag, ".fifo_wr"}, 32'(bus.fifo_wr), 32'(exp_wr));
        checkOutput({tag, ".byte_cnt"}, 32'(bus.byte_cnt), 32'(exp_cnt));
        checkOutput({tag, ".overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        checkOutput({tag, ".lr_sel"}, 32'(mic_lr_sel), 32'd0);
    endtask

    // One capture session: start, settle, then bytes until done, max_bytes or abort_bit.
    // abort_bit is the 0-based capture bit index on which abort is raised (-1 = never).
    task automatic run_capture(input int ln, input int max_bytes, input int full_pct,
                               input int abort_bit, input bit finish);
        int         k;
        logic [7:0] b;
        bit         full;
        bit         last;
        bit         ab;
        applyStimulus(1'b1, 1'b0, ln, 1'($urandom), 1'b0);
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_cnt  = 0;
        exp_ovf  = 1'b0;
        checkStatus("start", 1'b0);
        for (int s = 0; s < SETTLE; s++) begin
            applyStimulus($urandom_range(0, 7) == 0, 1'b0, int'($urandom), 1'($urandom), 1'($urandom));
            checkStatus("settle", 1'b0);
        end
        k = 0;
        for (int n = 0; n < max_bytes && exp_busy; n++) begin
            if (fixed_bytes.size() != 0) b = fixed_bytes.pop_front();
            else b = 8'($urandom);
            if (full_plan.size() != 0) full = full_plan.pop_front();
            else full = ($urandom_range(0, 99) < full_pct);
            for (int i = 7; i >= 0 && exp_busy; i--) begin
                last = (i == 0);
                ab   = (k == abort_bit);
                applyStimulus($urandom_range(0, 7) == 0, ab, int'($urandom), b[i],
                              last ? full : 1'($urandom));
                k++;
                if (ab) begin
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                    checkStatus("abort", 1'b0);
                end else if (last && !full) begin
                    exp_cnt = (exp_cnt + 1) % CMOD;
                    if (ln != 0 && exp_cnt == ln) begin
                        exp_busy = 1'b0;
                        exp_done = 1'b1;
                    end
                    checkStatus("write", 1'b1);
                    checkOutput("fifo_din", 32'(bus.fifo_din), 32'(b));
                end else begin
                    if (last) exp_ovf = 1'b1;
                    checkStatus(last ? "drop" : "bit", 1'b0);
                end
            end
        end
        if (finish) begin
            if (exp_busy) begin
                applyStimulus(1'b0, 1'b1, 0, 1'($urandom), 1'b0);
                exp_busy = 1'b0;
                exp_done = 1'b1;
                checkStatus("abort_end", 1'b0);
            end
            applyStimulus(1'b0, 1'($urandom), int'($urandom), 1'($urandom), 1'($urandom));
            checkStatus("done_hold", 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_cnt  = 0;
        exp_ovf  = 1'b0;
        checkStatus("reset", 1'b0);
        checkOutput("reset.din", 32'(bus.fifo_din), 32'd0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b1, 3, 1'b0, 1'b0);
        checkStatus("idle_start_abort", 1'b0);

        fixed_bytes = '{8'hA5, 8'h3C};
        run_capture(2, 2, 0, -1, 1'b1);

        full_plan = '{1'b1, 1'b0, 1'b0};
        run_capture(3, 3, 0, -1, 1'b1);

        applyStimulus(1'b1, 1'b1, 2, 1'b0, 1'b0);
        checkStatus("done_start_abort", 1'b0);

        run_capture(5, 5, 0, 11, 1'b1);
        run_capture(5, 5, 0, 15, 1'b1);
        run_capture(0, 17, 0, -1, 1'b1);

        for (int r = 0; r < 8; r++) begin
            run_capture($urandom_range(0, 5), $urandom_range(1, 6), 25,
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1, 1'b1);
        end

        full_plan = '{1'b1, 1'b0};
        run_capture(0, 2, 0, -1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'($urandom), 1'b0);
        end
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_cnt  = 0;
        exp_ovf  = 1'b0;
        checkStatus("mid_reset1", 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        checkStatus("mid_reset2", 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        checkStatus("after_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
